// File: rtl/dsp_chain_sop2_acc_if.sv
// Beat and result bundle for the two-product cascade with burst accumulator.
interface dsp_chain_sop2_acc_if #(
    parameter int N_STAGES = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int CNT_W    = 16
);
    logic                         in_valid;
    logic                         in_last;
    logic                         acc_mode;
    logic [N_STAGES*DATA_W-1:0]   top_a;
    logic [N_STAGES*DATA_W-1:0]   top_b;
    logic [N_STAGES*DATA_W-1:0]   bot_a;
    logic [N_STAGES*DATA_W-1:0]   bot_b;
    logic [ACC_W-1:0]             result;
    logic [CNT_W-1:0]             out_count;
    logic                         out_valid;

    modport master (
        output in_valid, in_last, acc_mode, top_a, top_b, bot_a, bot_b,
        input  result, out_count, out_valid
    );

    modport slave (
        input  in_valid, in_last, acc_mode, top_a, top_b, bot_a, bot_b,
        output result, out_count, out_valid
    );
endinterface

// File: rtl/dsp_chain_sop2_acc.sv
// Cascade of two-product multiply-add stages with a burst accumulator at the tail.
//
// Tail FSM:
//   state | meaning
//   IDLE  | no burst open, acc and cnt are zero
//   ACCUM | burst open, acc/cnt hold the partial sum and beat count
module dsp_chain_sop2_acc #(
    parameter int N_STAGES = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dsp_chain_sop2_acc_if.slave  bus
);
    localparam int OP_W = 4 * DATA_W;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    logic [N_STAGES-1:0] v_sr, l_sr, m_sr;

    genvar k;
    generate
        for (k = 0; k < N_STAGES; k++) begin : g_stage
            logic [OP_W-1:0]          op_in;
            logic [OP_W-1:0]          op_al;
            logic signed [2*DATA_W-1:0] p_top;
            logic signed [2*DATA_W-1:0] p_bot;
            logic signed [ACC_W-1:0]  c_prev;
            logic signed [ACC_W-1:0]  c_reg;

            assign op_in = {bus.top_a[k*DATA_W +: DATA_W], bus.top_b[k*DATA_W +: DATA_W],
                            bus.bot_a[k*DATA_W +: DATA_W], bus.bot_b[k*DATA_W +: DATA_W]};

            if (k == 0) begin : g_head
                assign op_al  = op_in;
                assign c_prev = '0;
            end else begin : g_link
                logic [OP_W-1:0] op_d [k];

                // Delay this stage's operands by k cycles so they meet the cascade wavefront.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        for (int j = 0; j < k; j++) op_d[j] <= '0;
                    end else begin
                        op_d[0] <= op_in;
                        for (int j = 1; j < k; j++) op_d[j] <= op_d[j-1];
                    end
                end

                assign op_al  = op_d[k-1];
                assign c_prev = g_stage[k-1].c_reg;
            end

            assign p_top = $signed(op_al[4*DATA_W-1 -: DATA_W]) * $signed(op_al[3*DATA_W-1 -: DATA_W]);
            assign p_bot = $signed(op_al[2*DATA_W-1 -: DATA_W]) * $signed(op_al[DATA_W-1 -: DATA_W]);

            // Cascade register: previous partial sum plus both sign-extended products, wrapping.
            always_ff @(posedge clk) begin
                if (reset) c_reg <= '0;
                else       c_reg <= c_prev + ACC_W'(p_top) + ACC_W'(p_bot);
            end
        end
    endgenerate

    // Sideband bits ride alongside the last cascade stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_sr <= '0;
            l_sr <= '0;
            m_sr <= '0;
        end else begin
            v_sr[0] <= bus.in_valid;
            l_sr[0] <= bus.in_last;
            m_sr[0] <= bus.acc_mode;
            for (int i = 1; i < N_STAGES; i++) begin
                v_sr[i] <= v_sr[i-1];
                l_sr[i] <= l_sr[i-1];
                m_sr[i] <= m_sr[i-1];
            end
        end
    end

    logic                    tail_valid, tail_last, tail_mode;
    logic signed [ACC_W-1:0] tail_sum;

    assign tail_valid = v_sr[N_STAGES-1];
    assign tail_last  = l_sr[N_STAGES-1];
    assign tail_mode  = m_sr[N_STAGES-1];
    assign tail_sum   = g_stage[N_STAGES-1].c_reg;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, base_acc;
    logic [CNT_W-1:0]        cnt, base_cnt;
    logic                    emit_pass, emit_burst, acc_step;
    logic [ACC_W-1:0]        result_q;
    logic [CNT_W-1:0]        count_q;
    logic                    valid_q;

    // Tail state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Open a burst on a non-final accumulate beat, close it on the final one.
    always_comb begin
        state_nxt = state;
        if (tail_valid && tail_mode) state_nxt = tail_last ? IDLE : ACCUM;
    end

    // Decode the tail action; an idle tail starts from an empty accumulator.
    always_comb begin
        emit_pass  = 1'b0;
        emit_burst = 1'b0;
        acc_step   = 1'b0;
        base_acc   = (state == ACCUM) ? acc : '0;
        base_cnt   = (state == ACCUM) ? cnt : '0;
        if (tail_valid) begin
            if (!tail_mode)     emit_pass  = 1'b1;
            else if (tail_last) emit_burst = 1'b1;
            else                acc_step   = 1'b1;
        end
    end

    // Accumulator, counter and output registers; outputs hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= emit_pass | emit_burst;
            if (emit_pass) begin
                result_q <= tail_sum;
                count_q  <= CNT_W'(1);
            end
            if (emit_burst) begin
                result_q <= base_acc + tail_sum;
                count_q  <= base_cnt + CNT_W'(1);
                acc      <= '0;
                cnt      <= '0;
            end
            if (acc_step) begin
                acc <= base_acc + tail_sum;
                cnt <= base_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.out_count = count_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_dsp_chain_sop2_acc.sv
// Scoreboard bench: a beat-level model pushes expected outputs, a negedge monitor pops them.
module tb_dsp_chain_sop2_acc;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 40;
    localparam int AW2 = 33;
    localparam int CW  = 16;
    localparam int PW  = N * DW;
    localparam int LAT = N + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_chain_sop2_acc_if #(.N_STAGES(N), .DATA_W(DW), .ACC_W(AW),  .CNT_W(CW)) bus ();
    dsp_chain_sop2_acc_if #(.N_STAGES(N), .DATA_W(DW), .ACC_W(AW2), .CNT_W(CW)) bus33 ();

    assign bus33.in_valid = bus.in_valid;
    assign bus33.in_last  = bus.in_last;
    assign bus33.acc_mode = bus.acc_mode;
    assign bus33.top_a    = bus.top_a;
    assign bus33.top_b    = bus.top_b;
    assign bus33.bot_a    = bus.bot_a;
    assign bus33.bot_b    = bus.bot_b;

    dsp_chain_sop2_acc #(.N_STAGES(N), .DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    dsp_chain_sop2_acc #(.N_STAGES(N), .DATA_W(DW), .ACC_W(AW2), .CNT_W(CW)) dut33 (
        .clk(clk), .reset(reset), .bus(bus33));

    typedef struct {
        longint val;
        int     cnt;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;
    bit     mon_en = 1'b0;
    longint last_val = 0;
    int     last_cnt = 0;
    longint m_acc = 0;
    int     m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] tr(longint v, int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [PW-1:0] rep(logic [DW-1:0] x);
        logic [PW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = x;
        return r;
    endfunction

    function automatic logic [PW-1:0] rnd_ops();
        return {$urandom, $urandom};
    endfunction

    // Whole-beat sum: every stage contributes top_a*top_b + bot_a*bot_b.
    function automatic longint beat_sum(logic [PW-1:0] ta, logic [PW-1:0] tb,
                                        logic [PW-1:0] ba, logic [PW-1:0] bb);
        longint s = 0;
        for (int k = 0; k < N; k++) begin
            s += longint'($signed(ta[k*DW +: DW])) * longint'($signed(tb[k*DW +: DW]));
            s += longint'($signed(ba[k*DW +: DW])) * longint'($signed(bb[k*DW +: DW]));
        end
        return s;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic drive(bit v, bit l, bit m, logic [PW-1:0] ta, logic [PW-1:0] tb,
                         logic [PW-1:0] ba, logic [PW-1:0] bb);
        longint s;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.acc_mode = m;
        bus.top_a    = ta;
        bus.top_b    = tb;
        bus.bot_a    = ba;
        bus.bot_b    = bb;
        if (v && !reset) begin
            s = beat_sum(ta, tb, ba, bb);
            if (!m) begin
                q.push_back('{s, 1, cyc + LAT});
            end else if (l) begin
                q.push_back('{m_acc + s, m_cnt + 1, cyc + LAT});
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_acc += s;
                m_cnt++;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom), 1'($urandom), rnd_ops(), rnd_ops(), rnd_ops(), rnd_ops());
    endtask

    task automatic beat56(bit l, bit m);
        drive(1'b1, l, m, rep(16'd1), rep(16'd2), rep(16'd3), rep(16'd4));
    endtask

    // One reset cycle with a valid accumulate beat presented in it; that beat must be dropped.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.acc_mode = 1'b1;
        bus.top_a    = rep(16'd1);
        bus.top_b    = rep(16'd2);
        bus.bot_a    = rep(16'd3);
        bus.bot_b    = rep(16'd4);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        m_acc    = 0;
        m_cnt    = 0;
        last_val = 0;
        last_cnt = 0;
    endtask

    // Monitor: out_valid must pulse exactly on scheduled cycles; outputs hold otherwise.
    always @(negedge clk) begin
        bit ev;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_output_cycle", 64'(cyc), 64'(q[0].cyc));
                void'(q.pop_front());
            end
            ev = (q.size() > 0 && q[0].cyc == cyc);
            check("out_valid",    64'(bus.out_valid),   64'(ev));
            check("out_valid_33", 64'(bus33.out_valid), 64'(ev));
            if (ev) begin
                last_val = q[0].val;
                last_cnt = q[0].cnt;
                void'(q.pop_front());
            end
            check("result",       64'(bus.result),      tr(last_val, AW));
            check("result_33",    64'(bus33.result),    tr(last_val, AW2));
            check("out_count",    64'(bus.out_count),   tr(longint'(last_cnt), CW));
            check("out_count_33", 64'(bus33.out_count), tr(longint'(last_cnt), CW));
        end
    end

    initial begin
        logic [PW-1:0] ta;
        int            guard;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.acc_mode = 1'b0;
        bus.top_a    = '0;
        bus.top_b    = '0;
        bus.bot_a    = '0;
        bus.bot_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single pass-through beat: 56.
        beat56(1'b0, 1'b0);
        repeat (6) idle();

        // Three-beat burst: 168, count 3.
        beat56(1'b0, 1'b1);
        beat56(1'b0, 1'b1);
        beat56(1'b1, 1'b1);
        repeat (6) idle();

        // Signed extreme: 2^32, wraps negative at 33 bits.
        drive(1'b1, 1'b0, 1'b0, rep(16'h8000), rep(16'h8000), '0, '0);
        repeat (6) idle();

        // Bubbles and an interleaved pass-through beat inside an open burst.
        beat56(1'b0, 1'b1);
        idle();
        idle();
        drive(1'b1, 1'b1, 1'b0, rep(16'd1), rep(16'd1), '0, '0);
        beat56(1'b1, 1'b1);
        repeat (6) idle();

        // Reset with beats in flight and a burst open.
        beat56(1'b0, 1'b1);
        beat56(1'b0, 1'b1);
        beat56(1'b0, 1'b1);
        idle();
        do_reset();
        beat56(1'b1, 1'b1);
        repeat (6) idle();

        // Skew alignment: stage k top_a=k+1, top_b=beat+1.
        for (int k = 0; k < N; k++) ta[k*DW +: DW] = DW'(k + 1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, ta, rep(DW'(i + 1)), '0, '0);
        repeat (6) idle();

        // Randomised mix of modes, lasts and bubbles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else drive(1'b1, $urandom_range(0, 3) == 0, 1'($urandom), rnd_ops(), rnd_ops(),
                       rnd_ops(), rnd_ops());
        end

        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            idle();
            guard++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (3) idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
